// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder that steps operands and carry through one full-adder cell
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ z;
    assign co = (x & y) | (x & z) | (y & z);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_sr_d;
    logic             c_ff, fs, fc, accept, last;
    logic [CW-1:0]    cnt;

    full_adder u_fa (.x(a_sr[0]), .y(b_sr[0]), .z(c_ff), .s(fs), .co(fc));

    // start is honoured in IDLE and DONE, ignored while shifting
    always_comb begin
        accept  = start && state != SHIFT;
        last    = state == SHIFT && cnt == CW'(WIDTH - 1);
        s_sr_d  = {fs, s_sr[WIDTH-1:1]};
        state_d = accept ? SHIFT : last ? DONE : state == SHIFT ? SHIFT : IDLE;
    end

    assign busy = state == SHIFT;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c_ff  <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            c_ff <= cin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            s_sr <= s_sr_d;
            c_ff <= fc;
            cnt  <= cnt + CW'(1);
            if (last) begin
                sum   <= s_sr_d;
                carry <= fc;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and WIDTH=16
module tb_serial_adder;
    logic clk = 1'b0, rst_n = 1'b0;
    always #10 clk = ~clk;

    logic        s8 = 0, c8 = 0, busy8, done8, cy8;
    logic [7:0]  a8 = 0, b8 = 0, sum8;
    logic        s16 = 0, c16 = 0, busy16, done16, cy16;
    logic [15:0] a16 = 0, b16 = 0, sum16;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(cy8));
    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16), .cin(c16),
        .busy(busy16), .done(done16), .sum(sum16), .carry(cy16));

    int total = 0, bad = 0;
    logic [8:0]  q8[$];
    logic [16:0] q16[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // monitors: pop reference results on every done, and check outputs hold while busy
    logic [8:0]  prev8 = 0;
    logic [16:0] prev16 = 0;
    logic        pd8 = 0, pd16 = 0;

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL done8_unexpected: got %0h want none", {cy8, sum8});
            end else chk("result8", {cy8, sum8}, q8.pop_front());
            chk("done8_width", pd8, 1'b0);
        end
        if (busy8) chk("hold8", {cy8, sum8}, prev8);
        prev8 = {cy8, sum8};
        pd8 = done8;
    end

    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL done16_unexpected: got %0h want none", {cy16, sum16});
            end else chk("result16", {cy16, sum16}, q16.pop_front());
            chk("done16_width", pd16, 1'b0);
        end
        if (busy16) chk("hold16", {cy16, sum16}, prev16);
        prev16 = {cy16, sum16};
        pd16 = done16;
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int lat = 0, bc = 0;
        @(negedge clk);
        a8 = a; b8 = b; c8 = c; s8 = 1;
        q8.push_back(9'(a) + 9'(b) + 9'(c));
        do begin
            @(negedge clk);
            s8 = 0;
            lat++;
            if (busy8) bc++;
        end while (!done8 && lat < 40);
        chk("lat8", lat, 9);
        chk("busy8_cycles", bc, 8);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c);
        int lat = 0, bc = 0;
        @(negedge clk);
        a16 = a; b16 = b; c16 = c; s16 = 1;
        q16.push_back(17'(a) + 17'(b) + 17'(c));
        do begin
            @(negedge clk);
            s16 = 0;
            lat++;
            if (busy16) bc++;
        end while (!done16 && lat < 60);
        chk("lat16", lat, 17);
        chk("busy16_cycles", bc, 16);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, dn, dl, d1, d2, gap;
        #5;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_out8", {cy8, sum8}, 0);
        chk("rst_out16", {busy16, done16, cy16, sum16}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        run8(8'h5A, 8'h3C, 0);
        chk("basic", {cy8, sum8}, 9'h096);
        run8(8'hFF, 8'h01, 0);
        chk("chain1", {cy8, sum8}, 9'h100);
        run8(8'hFF, 8'hFF, 1);
        chk("chain2", {cy8, sum8}, 9'h1FF);

        // start pulsed mid-operation must be ignored
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; c8 = 0; s8 = 1;
        q8.push_back(9'h030);
        dn = 0; dl = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            s8 = (k == 3);
            if (k == 3) a8 = 8'hAA;
            if (done8) begin dn++; dl = k; end
        end
        chk("sbusy_dones", dn, 1);
        chk("sbusy_lat", dl, 9);
        chk("sbusy_sum", {cy8, sum8}, 9'h030);

        // back-to-back: start held through the DONE cycle
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; c8 = 0; s8 = 1;
        q8.push_back(9'h096);
        q8.push_back(9'h003);
        d1 = 0; d2 = 0; gap = 0;
        for (int k = 1; k <= 40 && d2 == 0; k++) begin
            @(negedge clk);
            a8 = 8'h01; b8 = 8'h02;
            if (done8) begin
                if (d1 == 0) d1 = k;
                else d2 = k;
            end
            s8 = (d1 == 0 || k == d1);
            if (!busy8 && !done8 && d2 == 0) gap++;
        end
        s8 = 0;
        chk("b2b_first", d1, 9);
        chk("b2b_second", d2, 18);
        chk("b2b_gap", gap, 0);
        chk("b2b_sum", {cy8, sum8}, 9'h003);

        // asynchronous reset mid-operation
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; c8 = 1; s8 = 1;
        q8.push_back(9'h089);
        repeat (4) begin @(negedge clk); s8 = 0; end
        rst_n = 0;
        #1;
        chk("mrst_busy", busy8, 0);
        chk("mrst_done", done8, 0);
        chk("mrst_out", {cy8, sum8}, 0);
        q8.delete();
        dn = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 1) rst_n = 1;
            if (done8) dn++;
        end
        chk("mrst_nodone", dn, 0);
        run8(8'hC3, 8'h3D, 1);
        chk("post_rst", {cy8, sum8}, 9'h101);

        for (int i = 0; i < 500; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        run16(16'hFFFF, 16'h0001, 0);
        chk("chain16", {cy16, sum16}, 17'h10000);
        for (int i = 0; i < 100; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("q8_empty", q8.size(), 0);
        chk("q16_empty", q16.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
